// File: rtl/sb_pkg.sv
// Sideband shared definitions: opcodes, header field positions,
// decoded message struct and the msgcode/subcode table.
package sb_pkg;

  localparam logic [4:0] SB_OP_MSG_NODATA = 5'b10010;
  localparam logic [4:0] SB_OP_MSG_DATA   = 5'b11011;

  localparam int SB_OPC_LSB  = 0;
  localparam int SB_CODE_LSB = 14;
  localparam int SB_SUB_LSB  = 32;
  localparam int SB_INFO_LSB = 40;
  localparam int SB_CP_BIT   = 62;
  localparam int SB_DP_BIT   = 63;

  typedef struct packed {
    logic [3:0] state;
    logic [3:0] sub_state;
    logic [3:0] msg_no;
  } sb_msg_t;

  // {msgcode, msgsubcode} -> {state, sub_state, msg_no}
  localparam int SB_TBL_N = 4;
  localparam logic [15:0] SB_TBL_KEY [SB_TBL_N] = '{
    16'h9501, 16'h9502, 16'h8500, 16'h9A03
  };
  localparam logic [11:0] SB_TBL_VAL [SB_TBL_N] = '{
    12'h123, 12'h124, 12'h201, 12'h315
  };

endpackage

// File: rtl/sb_rx_msg_lookup.sv
// Combinational {msgcode, subcode} lookup into the shared
// sideband message table.
module sb_rx_msg_lookup
  import sb_pkg::*;
(
  input  logic [7:0] msgcode,
  input  logic [7:0] subcode,
  output sb_msg_t    msg,
  output logic       hit
);

  always_comb begin
    msg = '0;
    hit = 1'b0;
    for (int i = 0; i < SB_TBL_N; i++) begin
      if (SB_TBL_KEY[i] == {msgcode, subcode}) begin
        msg = sb_msg_t'(SB_TBL_VAL[i]);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sb_rx_packet_decoder.sv
// Sideband RX decoder: pattern lock, parity, message decode.
// Parity checking enabled by `define SB_RX_PARITY_CHECK_EN.
module sb_rx_packet_decoder
  import sb_pkg::*;
#(
  parameter int          PATTERN_WORDS = 2,
  parameter logic [63:0] PATTERN_WORD  = 64'hAAAA_AAAA_AAAA_AAAA
) (
  input  logic        i_divided_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_rx_data_in,
  input  logic        i_rx_valid,
  input  logic        i_msg_ack,
  output logic [3:0]  o_state,
  output logic [3:0]  o_sub_state,
  output logic [3:0]  o_msg_no,
  output logic [2:0]  o_msg_info,
  output logic [15:0] o_data_bus,
  output logic        o_msg_valid,
  output logic        o_data_valid,
  output logic        o_rsp_delivered,
  output logic        o_pattern_samp_done,
  output logic        o_parity_err,
  output logic        o_decode_err,
  output logic        o_overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, HOLD} st_t;

  localparam logic [1:0] PAT_LAST = 2'(PATTERN_WORDS - 1);

  st_t        st;
  logic [1:0] pat_cnt;
  sb_msg_t    pend_msg;
  logic [2:0] pend_info;
  sb_msg_t    lk_msg;
  logic       hit;
  logic [4:0] op;
  logic       is_pat, known, cp_ok, dp_ok, take_hdr;
  logic       h_bad_cp, h_miss, h_nd, h_dat;
`ifdef SB_RX_PARITY_CHECK_EN
  logic       pend_dp;
`endif

  sb_rx_msg_lookup u_lookup (
    .msgcode (i_rx_data_in[SB_CODE_LSB +: 8]),
    .subcode (i_rx_data_in[SB_SUB_LSB +: 8]),
    .msg     (lk_msg),
    .hit     (hit)
  );

  always_comb begin
    op     = i_rx_data_in[SB_OPC_LSB +: 5];
    is_pat = i_rx_data_in == PATTERN_WORD;
    known  = hit & ((op == SB_OP_MSG_NODATA) |
                    (op == SB_OP_MSG_DATA));
`ifdef SB_RX_PARITY_CHECK_EN
    cp_ok  = i_rx_data_in[SB_CP_BIT] == ^i_rx_data_in[61:0];
    dp_ok  = pend_dp == ^i_rx_data_in;
`else
    cp_ok  = 1'b1;
    dp_ok  = 1'b1;
`endif
    h_bad_cp = ~cp_ok;
    h_miss   = cp_ok & ~known;
    h_nd     = cp_ok & known & (op == SB_OP_MSG_NODATA);
    h_dat    = cp_ok & known & (op == SB_OP_MSG_DATA);
    // an acked HOLD treats the incoming word like IDLE does
    take_hdr = i_rx_valid &
               ((st == IDLE) | ((st == HOLD) & i_msg_ack));
  end

  always_ff @(posedge i_divided_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st                  <= IDLE;
      pat_cnt             <= '0;
      pend_msg            <= '0;
      pend_info           <= '0;
`ifdef SB_RX_PARITY_CHECK_EN
      pend_dp             <= 1'b0;
`endif
      o_state             <= '0;
      o_sub_state         <= '0;
      o_msg_no            <= '0;
      o_msg_info          <= '0;
      o_data_bus          <= '0;
      o_msg_valid         <= 1'b0;
      o_data_valid        <= 1'b0;
      o_rsp_delivered     <= 1'b0;
      o_pattern_samp_done <= 1'b0;
      o_parity_err        <= 1'b0;
      o_decode_err        <= 1'b0;
      o_overflow          <= 1'b0;
    end else begin
      o_rsp_delivered     <= 1'b0;
      o_pattern_samp_done <= 1'b0;
      o_parity_err        <= 1'b0;
      o_decode_err        <= 1'b0;
      o_overflow          <= 1'b0;

      case (st)
        WAIT_DATA: begin
          if (i_rx_valid) begin
            if (!dp_ok) begin
              o_parity_err <= 1'b1;
              st           <= IDLE;
            end else begin
              o_state         <= pend_msg.state;
              o_sub_state     <= pend_msg.sub_state;
              o_msg_no        <= pend_msg.msg_no;
              o_msg_info      <= pend_info;
              o_data_bus      <= i_rx_data_in[15:0];
              o_msg_valid     <= 1'b1;
              o_data_valid    <= 1'b1;
              o_rsp_delivered <= 1'b1;
              st              <= HOLD;
            end
          end
        end
        HOLD: begin
          if (i_rx_valid && !i_msg_ack) begin
            o_overflow <= 1'b1;
          end else if (i_msg_ack && !i_rx_valid) begin
            o_msg_valid  <= 1'b0;
            o_data_valid <= 1'b0;
            st           <= IDLE;
          end
        end
        default: ;
      endcase

      if (take_hdr) begin
        o_msg_valid  <= 1'b0;
        o_data_valid <= 1'b0;
        st           <= IDLE;
        if (is_pat) begin
          if (pat_cnt == PAT_LAST) begin
            o_pattern_samp_done <= 1'b1;
            pat_cnt             <= '0;
          end else begin
            pat_cnt <= pat_cnt + 2'd1;
          end
        end else begin
          pat_cnt <= '0;
          unique case (1'b1)
            h_bad_cp: o_parity_err <= 1'b1;
            h_miss:   o_decode_err <= 1'b1;
            h_nd: begin
              o_state         <= lk_msg.state;
              o_sub_state     <= lk_msg.sub_state;
              o_msg_no        <= lk_msg.msg_no;
              o_msg_info      <= i_rx_data_in[SB_INFO_LSB +: 3];
              o_data_bus      <= '0;
              o_msg_valid     <= 1'b1;
              o_rsp_delivered <= 1'b1;
              st              <= HOLD;
            end
            h_dat: begin
              pend_msg  <= lk_msg;
              pend_info <= i_rx_data_in[SB_INFO_LSB +: 3];
`ifdef SB_RX_PARITY_CHECK_EN
              pend_dp   <= i_rx_data_in[SB_DP_BIT];
`endif
              st        <= WAIT_DATA;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sb_rx_packet_decoder.sv
// Bench for sb_rx_packet_decoder: directed plan steps plus random
// traffic against a transaction-level model of the decoder.
module tb_sb_rx_packet_decoder;

  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam int PW = 2;
`ifdef SB_RX_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        msg_ack = 1'b0;
  logic [3:0]  o_state, o_sub_state, o_msg_no;
  logic [2:0]  o_msg_info;
  logic [15:0] o_data_bus;
  logic        o_msg_valid, o_data_valid, o_rsp_delivered;
  logic        o_pattern_samp_done, o_parity_err;
  logic        o_decode_err, o_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sb_rx_packet_decoder dut (
    .i_divided_clk       (clk),
    .i_rst_n             (rst_n),
    .i_rx_data_in        (rx_data),
    .i_rx_valid          (rx_valid),
    .i_msg_ack           (msg_ack),
    .o_state             (o_state),
    .o_sub_state         (o_sub_state),
    .o_msg_no            (o_msg_no),
    .o_msg_info          (o_msg_info),
    .o_data_bus          (o_data_bus),
    .o_msg_valid         (o_msg_valid),
    .o_data_valid        (o_data_valid),
    .o_rsp_delivered     (o_rsp_delivered),
    .o_pattern_samp_done (o_pattern_samp_done),
    .o_parity_err        (o_parity_err),
    .o_decode_err        (o_decode_err),
    .o_overflow          (o_overflow)
  );

  // reference: message table and transaction-level decoder state
  logic [11:0] tbl [logic [15:0]];
  logic [15:0] keys [4] = '{16'h9501, 16'h9502, 16'h8500, 16'h9A03};

  bit          m_held, m_wait;
  int          m_run;
  logic [11:0] m_pmsg;
  logic [2:0]  m_pinfo;
  logic        m_pdp;
  logic        e_mv, e_dv, e_rsp, e_done, e_perr, e_derr, e_ovf;
  logic [11:0] e_msg;
  logic [2:0]  e_info;
  logic [15:0] e_bus;
  logic [63:0] next_data;

  function automatic void m_reset();
    m_held = 0; m_wait = 0; m_run = 0;
    {e_mv, e_dv, e_rsp, e_done, e_perr, e_derr, e_ovf} = '0;
    e_msg = '0; e_info = '0; e_bus = '0;
  endfunction

  function automatic void deliver(logic [11:0] msg, logic [2:0] info,
                                  logic [15:0] bus, logic dv);
    m_held = 1; e_mv = 1; e_dv = dv; e_rsp = 1;
    e_msg = msg; e_info = info; e_bus = bus;
  endfunction

  function automatic void model(logic v, logic [63:0] d, logic a);
    logic [15:0] key;
    logic [4:0]  opc;
    {e_rsp, e_done, e_perr, e_derr, e_ovf} = '0;
    if (m_held) begin
      if (v && !a) begin e_ovf = 1; return; end
      if (a) begin m_held = 0; e_mv = 0; e_dv = 0; end
      if (!v) return;
    end else if (m_wait) begin
      if (!v) return;
      m_wait = 0;
      if (PAR && ((^d) != m_pdp)) begin e_perr = 1; return; end
      deliver(m_pmsg, m_pinfo, d[15:0], 1'b1);
      return;
    end else if (!v) return;
    if (d == PAT) begin
      m_run++;
      if (m_run == PW) begin e_done = 1; m_run = 0; end
      return;
    end
    m_run = 0;
    if (PAR && (d[62] != ^d[61:0])) begin e_perr = 1; return; end
    key = {d[21:14], d[39:32]};
    opc = d[4:0];
    if (!tbl.exists(key) || (opc != 5'b10010 && opc != 5'b11011)) begin
      e_derr = 1; return;
    end
    if (opc == 5'b10010) deliver(tbl[key], d[42:40], 16'h0, 1'b0);
    else begin
      m_wait = 1; m_pmsg = tbl[key]; m_pinfo = d[42:40]; m_pdp = d[63];
    end
  endfunction

  function automatic logic [63:0] mk_hdr(logic [4:0] opc, logic [15:0] key,
      logic [15:0] info, logic [63:0] data, bit flip_cp);
    logic [63:0] h;
    h = '0;
    h[4:0] = opc;
    h[21:14] = key[15:8];
    h[39:32] = key[7:0];
    h[55:40] = info;
    h[63] = (opc == 5'b11011) ? ^data : 1'b0;
    h[62] = (^h[61:0]) ^ flip_cp;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ctl"},
        64'({o_msg_valid, o_data_valid, o_rsp_delivered,
             o_pattern_samp_done, o_parity_err, o_decode_err, o_overflow}),
        64'({e_mv, e_dv, e_rsp, e_done, e_perr, e_derr, e_ovf}));
    if (e_mv)
      chk({tag, ".fld"},
          64'({o_state, o_sub_state, o_msg_no, o_msg_info, o_data_bus}),
          64'({e_msg, e_info, e_bus}));
  endtask

  task automatic step(input string tag, input logic v,
                      input logic [63:0] d, input logic a);
    @(negedge clk);
    rx_valid = v; rx_data = d; msg_ack = a;
    @(posedge clk);
    model(v, d, a);
    #1;
    check_model(tag);
  endtask

  logic [63:0] w;
  logic [63:0] hnd, hd;

  initial begin
    tbl[16'h9501] = 12'h123;
    tbl[16'h9502] = 12'h124;
    tbl[16'h8500] = 12'h201;
    tbl[16'h9A03] = 12'h315;
    m_reset();
    next_data = 64'h1234;

    #12;
    chk("reset_outputs",
        {26'h0, o_state, o_sub_state, o_msg_no, o_msg_info, o_data_bus,
         o_msg_valid, o_data_valid, o_rsp_delivered, o_pattern_samp_done,
         o_parity_err, o_decode_err, o_overflow}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // pattern lock, then an interrupted pattern
    step("pat1", 1, PAT, 0);
    step("pat2", 1, PAT, 0);
    chk("pat_done", 64'(o_pattern_samp_done), 64'd1);
    step("pat_idle", 0, PAT, 0);
    chk("pat_done_pulse", 64'(o_pattern_samp_done), 64'd0);
    step("pat3", 1, PAT, 0);
    step("pat_break", 1, 64'h5, 0);
    step("pat4", 1, PAT, 0);
    chk("pat_no_lock", 64'(o_pattern_samp_done), 64'd0);

    // no-data message, table row 0
    hnd = mk_hdr(5'b10010, 16'h9501, 16'h0005, '0, 0);
    step("nd_hdr", 1, hnd, 0);
    chk("nd_fields",
        64'({o_msg_valid, o_state, o_sub_state, o_msg_no, o_msg_info,
             o_data_bus, o_rsp_delivered}),
        64'({1'b1, 4'd1, 4'd2, 4'd3, 3'b101, 16'h0, 1'b1}));
    step("nd_hold", 0, '0, 0);
    // overflow, then ack together with a new header
    step("ovf", 1, mk_hdr(5'b10010, 16'h8500, 16'h2, '0, 0), 0);
    chk("ovf_pulse", 64'({o_overflow, o_msg_no}), 64'({1'b1, 4'd3}));
    step("ack_new", 1, mk_hdr(5'b10010, 16'h8500, 16'h2, '0, 0), 1);
    chk("ack_new_fld", 64'({o_msg_valid, o_state, o_msg_no}),
        64'({1'b1, 4'd2, 4'd1}));
    step("ack", 0, '0, 1);
    chk("ack_clear", 64'(o_msg_valid), 64'd0);

    // data message, good and bad data parity
    hd = mk_hdr(5'b11011, 16'h9A03, 16'h7, 64'h1234, 0);
    step("d_hdr", 1, hd, 0);
    step("d_data", 1, 64'h1234, 0);
    chk("d_fields", 64'({o_data_valid, o_data_bus}),
        64'({1'b1, 16'h1234}));
    step("d_ack", 0, '0, 1);
    step("d_hdr2", 1, hd, 0);
    step("d_bad", 1, 64'h1235, 0);
    step("d_bad_idle", 0, '0, 0);

    // flipped control parity
    step("cp_bad", 1, mk_hdr(5'b10010, 16'h9502, 16'h1, '0, 1), 0);
    step("cp_after", 0, '0, 1);

    // reset while waiting for data
    step("r_hdr", 1, hd, 0);
    @(negedge clk);
    rx_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_reset",
        {26'h0, o_state, o_sub_state, o_msg_no, o_msg_info, o_data_bus,
         o_msg_valid, o_data_valid, o_rsp_delivered, o_pattern_samp_done,
         o_parity_err, o_decode_err, o_overflow}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("r_data_alone", 1, 64'h1234, 0);
    chk("r_no_msg", 64'(o_msg_valid), 64'd0);
    step("r_hdr2", 1, hnd, 0);
    step("r_ack", 0, '0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [15:0] k;
      r = $urandom_range(0, 9);
      k = keys[$urandom_range(0, 3)];
      if (m_wait && $urandom_range(0, 2) != 0) begin
        w = next_data;
        if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 63)] ^= 1'b1;
      end else if (r < 2) begin
        w = PAT;
      end else if (r < 6) begin
        next_data = {$urandom, $urandom};
        w = mk_hdr(($urandom_range(0, 1) != 0) ? 5'b11011 : 5'b10010,
                   k, 16'($urandom), next_data, 0);
      end else if (r == 6) begin
        w = mk_hdr(5'b10010, k, 16'($urandom), '0, 1);
      end else if (r == 7) begin
        w = mk_hdr(($urandom_range(0, 1) != 0) ? 5'b10010 : 5'h1F,
                   16'h1111, 16'($urandom), '0, 0);
      end else begin
        w = {$urandom, $urandom};
      end
      step("rand", $urandom_range(0, 9) < 8, w, $urandom_range(0, 9) < 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sb_rx_packet_decoder.md
# sb_rx_packet_decoder

Sideband receive-path decoder: the counterpart of the TX packet encoder/framing chain. It accepts deserialized 64-bit sideband words at the divided clock and recognises the start-of-training pattern. It checks control/data parity on header and data words and maps message codes back to the `{state, sub_state, msg_no, msg_info, data_bus}` tuple used by the link-training FSMs. It also generates the `pattern_samp_done` / `rsp_delivered` indications consumed by the TX side.

## Interface
Parameters:
- `PATTERN_WORDS`, default 2: consecutive pattern words required before `o_pattern_samp_done` is asserted. Legal range 1–3.
- `PATTERN_WORD`, default 64'hAAAA_AAAA_AAAA_AAAA: the start-pattern word value.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `i_divided_clk` and `i_rst_n`.
- `i_divided_clk`  in  1  sideband divided clock; all logic on its rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_rx_data_in`  in  64  deserialized sideband word.
- `i_rx_valid`  in  1  `i_rx_data_in` valid this cycle; one word per cycle.
- `i_msg_ack`  in  1  consumer accepts the held message (single-cycle pulse).
- `o_state`, `o_sub_state`, `o_msg_no`  out  4 each  decoded message identity.
- `o_msg_info`  out  3  equals `msginfo[2:0]`.
- `o_data_bus`  out  16  equals data word `[15:0]`; 0 for messages without data.
- `o_msg_valid`  out  1  decoded message held; level signal.
- `o_data_valid`  out  1  held message carried data; qualifies `o_data_bus`.
- `o_rsp_delivered`  out  1  one-cycle pulse per accepted message.
- `o_pattern_samp_done`  out  1  one-cycle pulse on pattern lock.
- `o_parity_err`, `o_decode_err`, `o_overflow`  out  1 each  one-cycle error pulses.

## Operation
- Header word fields:
  - `[4:0]` opcode: 5'b10010 = message without data, 5'b11011 = message with 64-bit data.
  - `[21:14]` msgcode; `[39:32]` msgsubcode; `[55:40]` msginfo.
  - `[62]` CP: must equal `^hdr[61:0]`.
  - `[63]` DP: must equal `^data[63:0]`, or 0 when there is no data.
- Lookup: `{msgcode, msgsubcode}` maps through the package table to `{state, sub_state, msg_no}`. A miss raises `o_decode_err`.
- FSM states are IDLE, WAIT_DATA and HOLD.
- IDLE, on `i_rx_valid`:
  - Word == `PATTERN_WORD`: increment the pattern counter. When the count reaches `PATTERN_WORDS`, pulse `o_pattern_samp_done` and clear the counter.
  - Any other word clears the pattern counter, then:
    - CP bad: `o_parity_err`, stay in IDLE.
    - Unknown opcode or table miss: `o_decode_err`, stay in IDLE.
    - No-data opcode: latch outputs, `o_data_bus`=0, go to HOLD, pulse `o_rsp_delivered`.
    - Data opcode: latch header fields and DP, go to WAIT_DATA.
- WAIT_DATA:
  - The next valid word is data, even if it equals `PATTERN_WORD`.
  - DP mismatch: `o_parity_err`, go to IDLE, message discarded.
  - Otherwise: latch `[15:0]`, set `o_data_valid`, go to HOLD, pulse `o_rsp_delivered`.
  - No timeout; the FSM waits indefinitely.
- HOLD:
  - `o_msg_valid`=1 and outputs are stable until `i_msg_ack`.
  - `i_msg_ack` with no valid word: go to IDLE, clear `o_msg_valid` and `o_data_valid`.
  - `i_msg_ack` and `i_rx_valid` in the same cycle: the word is processed exactly as in IDLE. A new message re-enters HOLD with no gap.
  - `i_rx_valid` without `i_msg_ack`: pulse `o_overflow`, drop the word, held message unchanged.
- `i_msg_ack` outside HOLD is ignored.

## Timing
- Reset values: all outputs 0; FSM in IDLE; pattern counter 0.
- Latency: a word sampled at edge N produces registered outputs and pulses after edge N; they are visible during cycle N+1.
- `o_msg_valid` rises one cycle after the header (no-data message) or after the data word (data message).
- After `i_msg_ack` at edge M, `o_msg_valid` is low after edge M.
- Throughput: one word per cycle. Back-to-back no-data messages sustain one per cycle only if the consumer acks in the same cycle `o_msg_valid` is seen.
- Error and done signals are pulses of exactly one cycle; events in the same cycle may assert several simultaneously.
- Reset mid-operation: an asynchronous reset mid-message or mid-pattern discards the partial message or pattern count immediately.

## Configuration
- Macro `SB_RX_PARITY_CHECK_EN`.
- Defined: CP and DP are checked as above.
- Undefined: parity bits are ignored, `o_parity_err` is tied 0, and all words decode as if parity is good.

## Structure
- Shared package `sb_pkg` holds:
  - opcode constants `SB_OP_MSG_NODATA` / `SB_OP_MSG_DATA`;
  - header field bit-position localparams;
  - the `sb_msg_t` struct `{state, sub_state, msg_no}`;
  - the msgcode/subcode table, shared with the TX header encoder so both directions stay consistent.
- One sub-module `sb_rx_msg_lookup`: combinational `{msgcode, subcode}` → `{sb_msg_t, hit}`.
- Everything else (FSM, pattern counter, output registers) stays in `sb_rx_packet_decoder`.

## Test plan
- **Pattern lock:** two consecutive valid words 64'hAAAA_AAAA_AAAA_AAAA → `o_pattern_samp_done` pulses once, in the cycle after the second word. A non-pattern word between them → no pulse.
- **No-data message:** header with opcode 5'b10010, msgcode 8'h95, subcode 8'h01, msginfo 16'h0005, correct CP → next cycle `o_msg_valid`=1, `o_state`=1, `o_sub_state`=2, `o_msg_no`=3, `o_msg_info`=3'b101, `o_data_bus`=0, one `o_rsp_delivered` pulse. This uses package table row 0: 8'h95/8'h01 → 1/2/3.
- **Data message:** opcode 5'b11011 header, then data word 64'h0000_0000_0000_1234 with correct DP → `o_data_valid`=1, `o_data_bus`=16'h1234. Flip one data bit → `o_parity_err` pulse, no `o_msg_valid`.
- **Bad control parity:** header CP flipped → `o_parity_err` pulse, FSM stays in IDLE. With the macro undefined → message decoded normally.
- **Overflow:** in HOLD, send a second header without ack → `o_overflow` pulse, outputs unchanged. Then send a header in the same cycle as `i_msg_ack` → new message held next cycle.
- **Reset mid-message:** assert `i_rst_n`=0 in WAIT_DATA → all outputs 0. After release, a data word alone produces no message, and a fresh header decodes correctly.
